// File: rtl/pipe_stage_skid_pkg.sv
// Shared widths and state encoding for the ID->EX skid stage.
package pipe_stage_skid_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int DATA_BUS_W  = 32;
  localparam int REG_ADDR_W  = 5;

  localparam int DATA_W_DEF  = 128;
  localparam int CNT_W_DEF   = 16;

  // Encoding doubles as the held-beat count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle for the skid stage.
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              up_valid;
  logic              up_ready;
  logic [DATA_W-1:0] up_data;
  logic              up_is_branch;
  logic              dn_valid;
  logic              dn_ready;
  logic [DATA_W-1:0] dn_data;
  logic              dn_is_in_delayslot;

  modport slave (
    input  up_valid, up_data, up_is_branch, dn_ready,
    output up_ready, dn_valid, dn_data, dn_is_in_delayslot
  );

  modport master (
    output up_valid, up_data, up_is_branch, dn_ready,
    input  up_ready, dn_valid, dn_data, dn_is_in_delayslot
  );

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_d = (inc_i && (cnt_q != '1)) ? cnt_q + W'(1) : cnt_q;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid buffer between ID and EX with delay-slot tagging,
// flush, and a saturating downstream-bubble counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  bus,
  output logic              dn_next_in_delayslot,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              tag;
  } entry_t;

  state_e state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d, in_e;
  logic   pend_q, pend_d;
  logic   up_ready_q;
  logic   push, pop;

  assign push = bus.up_valid & up_ready_q;
  assign pop  = bus.dn_valid & bus.dn_ready;
  assign in_e = '{data: bus.up_data, tag: pend_q};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    pend_d  = pend_q;
    if (flush) begin
      // Flush beats both push and pop; payload may stay stale.
      state_d     = ST_EMPTY;
      pend_d      = 1'b0;
      head_d.tag  = 1'b0;
      skid_d.tag  = 1'b0;
    end else begin
      if (push) pend_d = bus.up_is_branch;
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = in_e;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_d = in_e;
          end else if (push) begin
            skid_d  = in_e;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      pend_q     <= 1'b0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      pend_q     <= pend_d;
      up_ready_q <= (state_d != ST_FULL);
    end
  end

  assign bus.up_ready           = up_ready_q;
  assign bus.dn_valid           = (state_q != ST_EMPTY);
  assign bus.dn_data            = head_q.data;
  assign bus.dn_is_in_delayslot = head_q.tag;
  assign dn_next_in_delayslot   = pend_q;
  assign occupancy              = state_q;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~bus.dn_valid & bus.dn_ready),
    .cnt_o (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a queue scoreboard on the EX side.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          dn_next_in_delayslot;
  logic [1:0]    occupancy;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_skid_if #(.DATA_W(DW)) bus ();

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .bus                  (bus),
    .dn_next_in_delayslot (dn_next_in_delayslot),
    .occupancy            (occupancy),
    .bubble_cnt           (bubble_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_q[$];
  logic        pend_m = 1'b0;
  int          exp_bub = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic br,
                       input logic rdy, input logic fl);
    bus.up_valid     = v;
    bus.up_data      = d;
    bus.up_is_branch = br;
    bus.dn_ready     = rdy;
    flush            = fl;
    if (fl) pend_m = 1'b0;
    else if (v && bus.up_ready) begin
      exp_q.push_back({d, pend_m});
      pend_m = br;
    end
  endtask

  // Monitor: the handshake seen mid-cycle is the one the next edge commits.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!bus.dn_valid && bus.dn_ready && exp_bub < (1 << CW) - 1) exp_bub++;
      if (flush) begin
        exp_q.delete();
      end else if (bus.dn_valid && bus.dn_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", bus.dn_data);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(bus.dn_data), 64'(e[DW:1]));
          chk("beat_tag", 64'(bus.dn_is_in_delayslot), 64'(e[0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_occ", 64'(occupancy), 0);
    chk("rst_dn_valid", 64'(bus.dn_valid), 0);
    chk("rst_up_ready", 64'(bus.up_ready), 1);
    chk("rst_pend", 64'(dn_next_in_delayslot), 0);
    chk("rst_tag", 64'(bus.dn_is_in_delayslot), 0);
    chk("rst_data", 64'(bus.dn_data), 0);
    chk("rst_bubble", 64'(bubble_cnt), 0);
    rst = 1'b0;

    // Streaming with dn_ready high: 1-cycle latency, occupancy 1.
    drive(1, 32'h1, 0, 1, 0);
    tick(); chk("s1_data", 64'(bus.dn_data), 32'h1); chk("s1_occ", 64'(occupancy), 1);
    drive(1, 32'h2, 0, 1, 0);
    tick(); chk("s2_data", 64'(bus.dn_data), 32'h2); chk("s2_occ", 64'(occupancy), 1);
    drive(1, 32'h3, 0, 1, 0);
    tick(); chk("s3_data", 64'(bus.dn_data), 32'h3); chk("s3_occ", 64'(occupancy), 1);
    drive(0, 0, 0, 1, 0);
    tick(); chk("s_drain_occ", 64'(occupancy), 0);
    chk("s_bubble", 64'(bubble_cnt), 64'(exp_bub));

    // Backpressure fills the skid entry.
    drive(1, 32'hA, 0, 0, 0);
    tick(); chk("bp1_occ", 64'(occupancy), 1); chk("bp1_rdy", 64'(bus.up_ready), 1);
    drive(1, 32'hB, 0, 0, 0);
    tick(); chk("bp2_occ", 64'(occupancy), 2); chk("bp2_rdy", 64'(bus.up_ready), 0);
    drive(1, 32'hC, 0, 0, 0);
    tick(); chk("bp_hold_data", 64'(bus.dn_data), 32'hA); chk("bp_hold_occ", 64'(occupancy), 2);
    drive(0, 0, 0, 1, 0);
    tick(); chk("bp3_occ", 64'(occupancy), 1); chk("bp3_rdy", 64'(bus.up_ready), 1);
    chk("bp3_data", 64'(bus.dn_data), 32'hB);
    tick(); chk("bp4_occ", 64'(occupancy), 0);

    // Delay-slot tagging.
    drive(1, 32'h10, 1, 1, 0);
    tick(); chk("br_tag", 64'(bus.dn_is_in_delayslot), 0); chk("br_pend", 64'(dn_next_in_delayslot), 1);
    drive(1, 32'h14, 0, 1, 0);
    tick(); chk("ds_tag", 64'(bus.dn_is_in_delayslot), 1); chk("ds_pend", 64'(dn_next_in_delayslot), 0);
    drive(1, 32'h18, 0, 1, 0);
    tick(); chk("post_tag", 64'(bus.dn_is_in_delayslot), 0);
    drive(0, 0, 0, 1, 0);
    tick();

    // Flush while FULL with pending flag set.
    drive(1, 32'h21, 0, 0, 0);
    tick();
    drive(1, 32'h22, 1, 0, 0);
    tick(); chk("fl_pre_occ", 64'(occupancy), 2); chk("fl_pre_pend", 64'(dn_next_in_delayslot), 1);
    drive(1, 32'h23, 0, 1, 1);
    tick(); chk("fl_occ", 64'(occupancy), 0); chk("fl_valid", 64'(bus.dn_valid), 0);
    chk("fl_pend", 64'(dn_next_in_delayslot), 0); chk("fl_rdy", 64'(bus.up_ready), 1);
    drive(0, 0, 0, 1, 0);
    tick(); chk("fl_after_occ", 64'(occupancy), 0);
    chk("fl_bubble", 64'(bubble_cnt), 64'(exp_bub));

    // Asynchronous reset between edges while FULL.
    drive(1, 32'h31, 0, 0, 0);
    tick();
    drive(1, 32'h32, 0, 0, 0);
    tick(); chk("ar_pre_occ", 64'(occupancy), 2);
    drive(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1; exp_q.delete(); pend_m = 1'b0; exp_bub = 0;
    #1;
    chk("ar_occ", 64'(occupancy), 0); chk("ar_valid", 64'(bus.dn_valid), 0);
    chk("ar_bubble", 64'(bubble_cnt), 0);
    tick();
    rst = 1'b0;
    drive(1, 32'h5, 0, 0, 0);
    tick(); chk("ar_push_valid", 64'(bus.dn_valid), 1); chk("ar_push_data", 64'(bus.dn_data), 32'h5);
    chk("ar_push_occ", 64'(occupancy), 1);
    drive(0, 0, 0, 1, 0);
    tick(); chk("ar_pop_occ", 64'(occupancy), 0);

    // Bubble counter: 5 bubbles, then saturate after 2^CW+3 total.
    repeat (5) tick();
    chk("bub5", 64'(bubble_cnt), 5);
    repeat (14) tick();
    chk("bub_sat", 64'(bubble_cnt), 4'hF);
    chk("bub_model", 64'(bubble_cnt), 64'(exp_bub));

    tick();
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
